i2c_slave: RTL
==============

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The module SHALL have parameter SLAVE_ADDR, default 7'h50, giving the 7-bit bus address the block answers to.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for scl_i/sda_i (legal range 2..3).
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port scl_i, input, 1 bit: bus SCL level, asynchronous to clk_i.
REQ-006 The module SHALL have port sda_i, input, 1 bit: bus SDA level, asynchronous to clk_i.
REQ-007 The module SHALL have port scl_o, output, 1 bit: SCL pull-down request (0 = pull low); held at 1 because there is no clock stretching.
REQ-008 The module SHALL have port sda_o, output, 1 bit: SDA pull-down request (0 = pull low, 1 = release).
REQ-009 The module SHALL have port wr_data_o, output, 32 bits: received write bytes; byte n lands in bits [8n+7:8n].
REQ-010 The module SHALL have port wr_len_o, output, 3 bits: number of write bytes ACKed in the last write transfer (0..4).
REQ-011 The module SHALL have port wr_valid_o, output, 1 bit: one-cycle pulse marking wr_data_o/wr_len_o valid.
REQ-012 The module SHALL have port rd_data_i, input, 32 bits: read payload; bits [7:0] are sent first.
REQ-013 The module SHALL have port rd_req_o, output, 1 bit: one-cycle pulse on the cycle rd_data_i is captured.
REQ-014 The module SHALL have port busy_o, output, 1 bit: high from address match until STOP, START or abort.

Function
REQ-015 The module SHALL use scl_i/sda_i only after SYNC_STAGES flops; all edge detection SHALL be done on the synchronized values.
REQ-016 The module SHALL detect START as synced SDA falling while synced SCL is high, from any state; it then enters ADDR with bit_cnt=0 and byte_cnt=0.
REQ-017 The module SHALL detect STOP as synced SDA rising while synced SCL is high, from any state; it then enters IDLE.
REQ-018 The module SHALL have states IDLE, ADDR, ACK_A, WDATA, ACK_W, RDATA, ACK_R and WAIT_STOP.
REQ-019 In ADDR and WDATA the module SHALL sample SDA on each SCL rising edge, MSB first, and treat the byte as complete at the 8th rising edge.
REQ-020 On address mismatch the module SHALL enter WAIT_STOP, keep sda_o=1 and keep busy_o=0.
REQ-021 On address match the module SHALL set busy_o=1 and drive sda_o=0 from the next SCL falling edge through the following SCL falling edge (ACK_A).
REQ-022 On address match with R/W=1 the module SHALL capture rd_data_i and pulse rd_req_o on the cycle the 8th address bit is sampled.
REQ-023 After ACK_A the module SHALL enter WDATA if R/W=0 and RDATA if R/W=1.
REQ-024 In WDATA, for byte_cnt<4, the module SHALL store the byte into lane byte_cnt, ACK it, increment byte_cnt, and return to WDATA.
REQ-025 In WDATA, for byte_cnt=4, the module SHALL NACK the byte (sda_o=1), discard it and enter WAIT_STOP.
REQ-026 In RDATA the module SHALL change sda_o only one clk_i cycle after a detected SCL falling edge, presenting lane byte_cnt MSB first.
REQ-027 In RDATA the module SHALL release SDA after the 8th bit so the master owns the ACK slot.
REQ-028 In ACK_R the module SHALL sample the master's ACK on the SCL rising edge; on ACK it increments byte_cnt (wrapping 3->0) and re-enters RDATA; on NACK it enters WAIT_STOP.
REQ-029 On STOP or repeated START ending a write with byte_cnt>0, the module SHALL pulse wr_valid_o for 1 cycle with wr_len_o=byte_cnt.
REQ-030 The module SHALL NOT pulse wr_valid_o for a write with zero data bytes.
REQ-031 On STOP, and on repeated START before re-entering ADDR, the module SHALL force sda_o=1 and busy_o=0.
REQ-032 wr_data_o SHALL hold its value between transfers; unwritten lanes SHALL retain their old contents.

Reset
REQ-033 When rst_i=1 the module SHALL be in IDLE with sda_o=1, scl_o=1, busy_o=0, wr_valid_o=0, rd_req_o=0, wr_len_o=0, wr_data_o=0, byte_cnt=0, bit_cnt=0, and synchronizers preset to 1.
REQ-034 Reset asserted mid-transfer SHALL release SDA within 1 cycle, and the module SHALL ignore the bus until the next START.

Structure
REQ-035 Shared package i2c_pkg SHALL hold the state enum, the ACK/NACK level constants and MAX_BYTES=4, and the master model SHALL use the same package.
REQ-036 Sub-module i2c_line_sync SHALL hold the SYNC_STAGES flops for SCL/SDA and output the synced levels plus scl_rise, scl_fall, start_det and stop_det pulses.

Verification
REQ-037 Write 0x50 with 4 bytes 0x11,0x22,0x33,0x44 then STOP -> 5 ACKs, wr_valid_o pulse, wr_data_o=32'h44332211, wr_len_o=4.
REQ-038 Read 0x50 with 4 bytes, rd_data_i=32'hDEADBEEF -> master receives EF,BE,AD,DE; rd_req_o pulses once; NACK on the last byte leads to WAIT_STOP.
REQ-039 Write to 0x51 -> address NACK (sda_o stays 1), busy_o=0, no wr_valid_o pulse.
REQ-040 Write 5 bytes to 0x50 -> 5th byte NACKed, wr_len_o=4 at STOP.
REQ-041 Write 2 bytes then repeated START and read 1 byte -> wr_valid_o pulses at the repeated START with wr_len_o=2, then the read returns lane 0.
REQ-042 rst_i asserted during the 3rd read bit -> sda_o=1 on the next cycle, and a subsequent 1-byte write to 0x50 completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave and anything that talks to it.
package i2c_pkg;

   localparam int   MAX_BYTES = 4;
   localparam logic ACK       = 1'b0;
   localparam logic NACK      = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_A,
      WDATA,
      ACK_W,
      RDATA,
      ACK_R,
      WAIT_STOP
   } i2c_state_e;

   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the raw SCL/SDA levels into clk_i and derives bus edge/condition pulses.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_s_o,
   output logic sda_s_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;

   // Preset to the idle bus level so leaving reset never looks like an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
         sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   assign scl_s_o     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s_o     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise_o  =  scl_s_o & ~scl_prev_q;
   assign scl_fall_o  = ~scl_s_o &  scl_prev_q;
   assign start_det_o =  scl_s_o &  scl_prev_q &  sda_prev_q & ~sda_s_o;
   assign stop_det_o  =  scl_s_o &  scl_prev_q & ~sda_prev_q &  sda_s_o;

endmodule

// File: rtl/i2c_slave.sv
// 7-bit address I2C slave: up to 4 write bytes into wr_data_o, reads served from a captured rd_data_i word.
//
// state     | meaning
// IDLE      | bus ignored until START
// ADDR      | shifting in address + R/W
// ACK_A     | address ACK slot (pull SDA low between two SCL falls)
// WDATA     | shifting in a write byte
// ACK_W     | write byte ACK slot
// RDATA     | driving read byte bits after each SCL fall
// ACK_R     | SDA released, master ACK/NACK sampled on SCL rise
// WAIT_STOP | not addressed / done, ignore bus until START or STOP
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        scl_o,
   output logic        sda_o,
   output logic [31:0] wr_data_o,
   output logic [2:0]  wr_len_o,
   output logic        wr_valid_o,
   input  logic [31:0] rd_data_i,
   output logic        rd_req_o,
   output logic        busy_o
);

   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .scl_i       (scl_i),
      .sda_i       (sda_i),
      .scl_s_o     (scl_s),
      .sda_s_o     (sda_s),
      .scl_rise_o  (scl_rise),
      .scl_fall_o  (scl_fall),
      .start_det_o (start_det),
      .stop_det_o  (stop_det)
   );

   // The synced SCL level is only consumed through its edge pulses.
   logic unused_scl_s;
   assign unused_scl_s = scl_s;

   i2c_state_e  state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        rw_q, rw_d;
   logic        wr_act_q, wr_act_d;
   logic        ack_drv_q, ack_drv_d;
   logic        sda_q, sda_d;
   logic        busy_q, busy_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [2:0]  wr_len_q, wr_len_d;
   logic        wr_valid_q, wr_valid_d;
   logic        rd_req_q, rd_req_d;
   logic [31:0] rd_buf_q, rd_buf_d;

   logic [7:0]  shift_nxt;
   logic [7:0]  rd_lane;
   logic        rd_bit;

   assign shift_nxt = {shift_q[6:0], sda_s};
   assign rd_lane   = lane_sel(rd_buf_q, byte_cnt_q[1:0]);
   assign rd_bit    = rd_lane[3'd7 - bit_cnt_q[2:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         rw_q       <= 1'b0;
         wr_act_q   <= 1'b0;
         ack_drv_q  <= 1'b0;
         sda_q      <= NACK;
         busy_q     <= 1'b0;
         wr_data_q  <= '0;
         wr_len_q   <= '0;
         wr_valid_q <= 1'b0;
         rd_req_q   <= 1'b0;
         rd_buf_q   <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         wr_act_q   <= wr_act_d;
         ack_drv_q  <= ack_drv_d;
         sda_q      <= sda_d;
         busy_q     <= busy_d;
         wr_data_q  <= wr_data_d;
         wr_len_q   <= wr_len_d;
         wr_valid_q <= wr_valid_d;
         rd_req_q   <= rd_req_d;
         rd_buf_q   <= rd_buf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      wr_act_d   = wr_act_q;
      ack_drv_d  = ack_drv_q;
      sda_d      = sda_q;
      busy_d     = busy_q;
      wr_data_d  = wr_data_q;
      wr_len_d   = wr_len_q;
      wr_valid_d = 1'b0;
      rd_req_d   = 1'b0;
      rd_buf_d   = rd_buf_q;

      if (start_det || stop_det) begin
         // A write is reported when it is ended, whichever condition ends it.
         if (wr_act_q && (byte_cnt_q != 3'd0)) begin
            wr_valid_d = 1'b1;
            wr_len_d   = byte_cnt_q;
         end
         sda_d      = NACK;
         busy_d     = 1'b0;
         wr_act_d   = 1'b0;
         ack_drv_d  = 1'b0;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         state_d    = start_det ? ADDR : IDLE;
      end else begin
         unique case (state_q)
            IDLE, WAIT_STOP: begin
            end
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = shift_nxt;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = '0;
                     if (shift_nxt[7:1] == SLAVE_ADDR) begin
                        busy_d   = 1'b1;
                        rw_d     = shift_nxt[0];
                        wr_act_d = ~shift_nxt[0];
                        state_d  = ACK_A;
                        if (shift_nxt[0]) begin
                           rd_buf_d = rd_data_i;
                           rd_req_d = 1'b1;
                        end
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end
            ACK_A, ACK_W: begin
               if (scl_fall) begin
                  if (!ack_drv_q) begin
                     ack_drv_d = 1'b1;
                     sda_d     = ACK;
                  end else begin
                     ack_drv_d = 1'b0;
                     if ((state_q == ACK_A) && rw_q) begin
                        sda_d     = rd_bit;
                        bit_cnt_d = 4'd1;
                        state_d   = RDATA;
                     end else begin
                        sda_d   = NACK;
                        state_d = WDATA;
                     end
                  end
               end
            end
            WDATA: begin
               if (scl_rise) begin
                  shift_d   = shift_nxt;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = '0;
                     if (byte_cnt_q < 3'(MAX_BYTES)) begin
                        wr_data_d[{byte_cnt_q[1:0], 3'b000} +: 8] = shift_nxt;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        state_d    = ACK_W;
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_d     = NACK;
                     bit_cnt_d = '0;
                     state_d   = ACK_R;
                  end else begin
                     sda_d     = rd_bit;
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ACK_R: begin
               if (scl_rise) begin
                  if (sda_s == ACK) begin
                     byte_cnt_d = (byte_cnt_q == 3'd3) ? 3'd0 : byte_cnt_q + 3'd1;
                     bit_cnt_d  = '0;
                     state_d    = RDATA;
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign scl_o      = 1'b1;
   assign sda_o      = sda_q;
   assign wr_data_o  = wr_data_q;
   assign wr_len_o   = wr_len_q;
   assign wr_valid_o = wr_valid_q;
   assign rd_req_o   = rd_req_q;
   assign busy_o     = busy_q;

endmodule
